// File: rtl/readout_scheduler.sv
// Readout sequencer for the impulse-counter bank: round-robin overflow service and ordered full dumps.
// Defining PERIODIC_DUMP_EN adds a free-running counter that requests a dump every DUMP_PERIOD cycles.

module readout_scheduler #(
  parameter int NUM_CH      = 9,
  parameter int DATA_W      = 12,
  parameter int SEL_W       = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int DUMP_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              start,
  output logic [SEL_W-1:0]  sel,
  output logic              load,
  output logic              shift_en,
  output logic [NUM_CH-1:0] clr,
  output logic              ch_done,
  output logic              busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CLEAR, GAP} state_t;

  state_t            state;
  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] pend;
  logic              dump_pend;
  logic              dump_mode;
  logic [SEL_W-1:0]  ptr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              period_wrap;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] clear_mask;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  sel_next;
  logic              rr_found;
  logic              word_end;
  logic              dump_take;

  // Source index arithmetic modulo NUM_CH; both operands are always below NUM_CH.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W-1:0] off);
    logic [SEL_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (SEL_W+1)'(NUM_CH)) sum = sum - (SEL_W+1)'(NUM_CH);
    return sum[SEL_W-1:0];
  endfunction

`ifdef PERIODIC_DUMP_EN
  localparam int PER_W = (DUMP_PERIOD > 1) ? $clog2(DUMP_PERIOD) : 1;

  logic [PER_W-1:0] period_cnt;

  assign period_wrap = (period_cnt == PER_W'(DUMP_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset)            period_cnt <= '0;
    else if (period_wrap) period_cnt <= '0;
    else                  period_cnt <= period_cnt + 1'b1;
  end
`else
  // No periodic source in this build; DUMP_PERIOD stays referenced so both builds share one interface.
  assign period_wrap = (DUMP_PERIOD < 0);
`endif

  assign rise       = req & ~req_q;
  assign sel_onehot = NUM_CH'(1) << sel;
  assign clear_mask = (state == CLEAR) ? sel_onehot : '0;
  assign sel_next   = wrap_add(sel, SEL_W'(1));
  assign dump_take  = (state == IDLE) && dump_pend;
  assign word_end   = ((state == CLEAR) && (GAP_CYCLES == 0)) ||
                      ((state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1)));

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    rr_idx   = '0;
    rr_found = 1'b0;
    // Walk offsets from far to near so the nearest set bit at or after ptr wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[wrap_add(ptr, SEL_W'(i))]) begin
        rr_idx   = wrap_add(ptr, SEL_W'(i));
        rr_found = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      load      <= 1'b0;
      shift_en  <= 1'b0;
      clr       <= '0;
      ch_done   <= 1'b0;
      busy      <= 1'b0;
      req_q     <= '0;
      pend      <= '0;
      dump_pend <= 1'b0;
      dump_mode <= 1'b0;
      ptr       <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      req_q <= req;
      // A rising edge in the clearing cycle wins over the clear.
      pend <= (pend & ~clear_mask) | rise;
      // Taking a dump swallows any request arriving that same cycle; all others collapse into one.
      dump_pend <= dump_take ? 1'b0 : (dump_pend | start | period_wrap);

      case (state)
        IDLE: begin
          if (dump_pend) begin
            dump_mode <= 1'b1;
            sel       <= '0;
            load      <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end else if (rr_found) begin
            sel   <= rr_idx;
            load  <= 1'b1;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          load     <= 1'b0;
          shift_en <= 1'b1;
          bit_cnt  <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            shift_en <= 1'b0;
            clr      <= sel_onehot;
            ch_done  <= 1'b1;
            state    <= CLEAR;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CLEAR: begin
          clr     <= '0;
          ch_done <= 1'b0;
          ptr     <= sel_next;
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: state   <= IDLE;
      endcase

      // End of a word overrides the per-state next state (also covers a zero-length gap).
      if (word_end) begin
        if (dump_mode && (sel != LAST_SEL)) begin
          sel   <= sel_next;
          load  <= 1'b1;
          state <= LOAD;
        end else begin
          dump_mode <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// Self-checking bench for readout_scheduler: a negedge monitor logs served words, and a
// transaction-level model predicts service order from the round-robin and dump rules.

module tb_readout_scheduler;

  localparam int NUM_CH     = 9;
  localparam int DATA_W     = 12;
  localparam int SEL_W      = 4;
  localparam int GAP_CYCLES = 2;
`ifdef PERIODIC_DUMP_EN
  // Longer than one full dump, so consecutive periodic dumps stay separable.
  localparam int DUMP_PERIOD = 200;
`else
  localparam int DUMP_PERIOD = 1000;
`endif
  localparam int WORD_CYC = 1 + DATA_W + 1 + GAP_CYCLES;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] req   = '0;
  logic              start = 1'b0;
  logic [SEL_W-1:0]  sel;
  logic              load;
  logic              shift_en;
  logic [NUM_CH-1:0] clr;
  logic              ch_done;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int served[$];
  int load_cyc[$];
  int proto_err = 0;
  int exp_q[$];
  int mdl_ptr = 0;

  readout_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W),
    .GAP_CYCLES(GAP_CYCLES), .DUMP_PERIOD(DUMP_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .start(start),
    .sel(sel), .load(load), .shift_en(shift_en), .clr(clr),
    .ch_done(ch_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  // Word protocol monitor: each word is one load, DATA_W shifts, then one one-hot clr with ch_done.
  initial begin
    bit in_word;
    int w_sel;
    int sh;
    logic [NUM_CH-1:0] oh;
    in_word = 1'b0;
    w_sel   = 0;
    sh      = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_word = 1'b0;
        sh      = 0;
      end else begin
        if (load) begin
          if (in_word || !busy || shift_en) proto_err++;
          in_word = 1'b1;
          w_sel   = int'(sel);
          sh      = 0;
          load_cyc.push_back(cyc);
        end
        if (shift_en) begin
          if (!in_word || int'(sel) != w_sel) proto_err++;
          sh++;
        end
        if (clr != '0) begin
          oh = '0;
          oh[w_sel] = 1'b1;
          if (!in_word || clr !== oh || ch_done !== 1'b1 || sh != DATA_W) proto_err++;
          served.push_back(w_sel);
          in_word = 1'b0;
        end else if (ch_done) begin
          proto_err++;
        end
        if (in_word && (!busy || int'(sel) != w_sel)) proto_err++;
        if (!busy && (load || shift_en || ch_done || clr != '0)) proto_err++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    served.delete();
    load_cyc.delete();
    exp_q.delete();
    proto_err = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_load(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (load) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Quiet means three consecutive idle samples: nothing pending and nothing in flight.
  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q  = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy || load) q = 0;
      else q++;
      if (q >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference model: a batch of simultaneous requests is served in ascending index order
  // starting at the pointer and wrapping; the pointer then sits one past the last served.
  function automatic void model_rr(input logic [NUM_CH-1:0] mask);
    int last;
    last = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      int k;
      k = (mdl_ptr + i) % NUM_CH;
      if (mask[k]) begin
        exp_q.push_back(k);
        last = k;
      end
    end
    if (last >= 0) mdl_ptr = (last + 1) % NUM_CH;
  endfunction

  // A dump reads every source in index order; the pointer wraps to 0 after the last one.
  function automatic void model_dump();
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(i);
    mdl_ptr = 0;
  endfunction

  function automatic int order_diff();
    int d;
    d = (served.size() > exp_q.size()) ? served.size() - exp_q.size() : exp_q.size() - served.size();
    for (int i = 0; i < served.size() && i < exp_q.size(); i++)
      if (served[i] != exp_q[i]) d++;
    return d;
  endfunction

  function automatic string q2s(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    start = 1'b0;
    repeat (3) tick();
    tests_run++; if (sel !== '0) begin tests_failed++; $display("FAIL reset_sel: got %0d, expected 0", sel); end
    tests_run++; if (load !== 1'b0) begin tests_failed++; $display("FAIL reset_load: got %b, expected 0", load); end
    tests_run++; if (shift_en !== 1'b0) begin tests_failed++; $display("FAIL reset_shift_en: got %b, expected 0", shift_en); end
    tests_run++; if (clr !== '0) begin tests_failed++; $display("FAIL reset_clr: got %b, expected 0", clr); end
    tests_run++; if (ch_done !== 1'b0) begin tests_failed++; $display("FAIL reset_ch_done: got %b, expected 0", ch_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset   = 1'b0;
    mdl_ptr = 0;
    repeat (3) tick();
    tests_run++; if ({busy, load} !== 2'b00) begin tests_failed++; $display("FAIL reset_idle_after_release: got busy/load %b, expected 00", {busy, load}); end
  endtask

`ifdef PERIODIC_DUMP_EN
  task automatic test_periodic();
    int base;
    reset = 1'b1;
    repeat (2) tick();
    clear_log();
    reset = 1'b0;
    base  = cyc;
    // The counter wraps on the DUMP_PERIOD-th edge after release; start lands on that same edge.
    repeat (DUMP_PERIOD - 1) tick();
    pulse_start();
    repeat (DUMP_PERIOD + 10) tick();
    model_dump();
    tests_run++; if (load_cyc.size() != NUM_CH + 1) begin tests_failed++; $display("FAIL periodic_load_count: got %0d, expected %0d", load_cyc.size(), NUM_CH + 1); end
    tests_run++; if (load_cyc.size() < 1 || load_cyc[0] - base != DUMP_PERIOD + 1) begin tests_failed++; $display("FAIL periodic_first_load: got %0d, expected %0d", (load_cyc.size() > 0) ? load_cyc[0] - base : -1, DUMP_PERIOD + 1); end
    tests_run++; if (load_cyc.size() < NUM_CH + 1 || load_cyc[NUM_CH] - base != 2 * DUMP_PERIOD + 1) begin tests_failed++; $display("FAIL periodic_second_dump: got %0d, expected %0d", (load_cyc.size() > NUM_CH) ? load_cyc[NUM_CH] - base : -1, 2 * DUMP_PERIOD + 1); end
    tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL periodic_order: got [%s], expected [%s]", q2s(served), q2s(exp_q)); end
    tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL periodic_protocol: got %0d errors, expected 0", proto_err); end
  endtask
`else
  task automatic test_single_req();
    int busy_n, shift_n, done_n;
    logic [NUM_CH-1:0] clr_seen;
    bit ok;
    clear_log();
    req[2] = 1'b1;
    tick();
    tests_run++; if ({load, busy} !== 2'b00) begin tests_failed++; $display("FAIL single_decision: got load/busy %b, expected 00", {load, busy}); end
    tick();
    tests_run++; if (load !== 1'b1) begin tests_failed++; $display("FAIL single_load: got %b, expected 1", load); end
    tests_run++; if (sel !== SEL_W'(2)) begin tests_failed++; $display("FAIL single_sel: got %0d, expected 2", sel); end
    busy_n = 0; shift_n = 0; done_n = 0; clr_seen = '0;
    for (int i = 0; i < 200 && busy; i++) begin
      busy_n++;
      if (shift_en) shift_n++;
      if (ch_done) done_n++;
      clr_seen |= clr;
      tick();
    end
    tests_run++; if (busy_n != WORD_CYC) begin tests_failed++; $display("FAIL single_busy_len: got %0d, expected %0d", busy_n, WORD_CYC); end
    tests_run++; if (shift_n != DATA_W) begin tests_failed++; $display("FAIL single_shift_len: got %0d, expected %0d", shift_n, DATA_W); end
    tests_run++; if (done_n != 1) begin tests_failed++; $display("FAIL single_ch_done: got %0d pulses, expected 1", done_n); end
    tests_run++; if (clr_seen !== 9'b000000100) begin tests_failed++; $display("FAIL single_clr: got %b, expected 000000100", clr_seen); end
    // req[2] is still held high: a level must not re-trigger.
    wait_quiet(100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_quiet_timeout: got busy, expected idle"); end
    req = '0;
    model_rr(9'b000000100);
    tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL single_order: got [%s], expected [%s]", q2s(served), q2s(exp_q)); end
    tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL single_protocol: got %0d errors, expected 0", proto_err); end
  endtask

  task automatic test_dump();
    int busy_n, bad_gap;
    bit ok;
    clear_log();
    pulse_start();
    wait_load(10, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL dump_load_timeout: got no load, expected one"); end
    tests_run++; if (sel !== '0) begin tests_failed++; $display("FAIL dump_first_sel: got %0d, expected 0", sel); end
    busy_n = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      busy_n++;
      tick();
    end
    tests_run++; if (busy_n != NUM_CH * WORD_CYC) begin tests_failed++; $display("FAIL dump_busy_len: got %0d, expected %0d", busy_n, NUM_CH * WORD_CYC); end
    wait_quiet(100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL dump_quiet_timeout: got busy, expected idle"); end
    model_dump();
    tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL dump_order: got [%s], expected [%s]", q2s(served), q2s(exp_q)); end
    tests_run++; if (load_cyc.size() != NUM_CH) begin tests_failed++; $display("FAIL dump_load_count: got %0d, expected %0d", load_cyc.size(), NUM_CH); end
    bad_gap = 0;
    for (int i = 1; i < load_cyc.size(); i++)
      if (load_cyc[i] - load_cyc[i-1] != WORD_CYC) bad_gap++;
    tests_run++; if (bad_gap != 0) begin tests_failed++; $display("FAIL dump_word_spacing: got %0d bad spacings, expected 0", bad_gap); end
    tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL dump_protocol: got %0d errors, expected 0", proto_err); end
  endtask

  task automatic test_round_robin();
    logic [NUM_CH-1:0] masks [3];
    bit ok;
    masks[0] = 9'b010100010;   // 1, 5, 7 from ptr 0
    masks[1] = 9'b000000001;   // 0 alone, wrapping from ptr 8
    masks[2] = 9'b100000001;   // 0 and 8 from ptr 1: 8 comes first
    for (int m = 0; m < 3; m++) begin
      clear_log();
      req = masks[m];
      tick();
      req = '0;
      wait_quiet(300, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr%0d_quiet_timeout: got busy, expected idle", m); end
      model_rr(masks[m]);
      tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL rr%0d_order: got [%s], expected [%s]", m, q2s(served), q2s(exp_q)); end
      tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL rr%0d_protocol: got %0d errors, expected 0", m, proto_err); end
    end
  endtask

  task automatic test_dump_edges();
    bit found, ok;
    clear_log();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (load && sel == SEL_W'(5)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL dump_edges_sel5_timeout: got no load at sel 5, expected one"); end
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    tick();
    req[7] = 1'b1;
    tick();
    req[7] = 1'b0;
    wait_quiet(600, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL dump_edges_quiet_timeout: got busy, expected idle"); end
    model_dump();
    model_rr(9'b000001000);
    tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL dump_edges_order: got [%s], expected [%s]", q2s(served), q2s(exp_q)); end
    tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL dump_edges_protocol: got %0d errors, expected 0", proto_err); end
  endtask

  task automatic test_reset_midshift();
    bit ok;
    clear_log();
    pulse_start();
    wait_load(10, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL midshift_load_timeout: got no load, expected one"); end
    repeat (7) tick();
    tests_run++; if (shift_en !== 1'b1) begin tests_failed++; $display("FAIL midshift_in_shift: got shift_en %b, expected 1", shift_en); end
    reset = 1'b1;
    tick();
    tests_run++; if ({load, shift_en, ch_done, busy} !== 4'b0000) begin tests_failed++; $display("FAIL midshift_ctrl: got load/shift/done/busy %b, expected 0000", {load, shift_en, ch_done, busy}); end
    tests_run++; if (clr !== '0) begin tests_failed++; $display("FAIL midshift_clr: got %b, expected 0", clr); end
    tests_run++; if (sel !== '0) begin tests_failed++; $display("FAIL midshift_sel: got %0d, expected 0", sel); end
    reset   = 1'b0;
    mdl_ptr = 0;
    repeat (5) tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midshift_no_resume: got busy %b, expected 0", busy); end
    tests_run++; if (served.size() != 0) begin tests_failed++; $display("FAIL midshift_no_clr: got %0d clr pulses, expected 0", served.size()); end
    clear_log();
    pulse_start();
    wait_load(10, ok);
    tests_run++; if (!ok || sel !== '0) begin tests_failed++; $display("FAIL midshift_restart_sel: got %0d, expected 0", sel); end
    wait_quiet(400, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL midshift_quiet_timeout: got busy, expected idle"); end
    model_dump();
    tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL midshift_order: got [%s], expected [%s]", q2s(served), q2s(exp_q)); end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit ok;
    clear_log();
    pulse_start();
    wait_load(10, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_load_timeout: got no load, expected one"); end
    repeat (5) tick();
    // Three starts during one dump collapse into a single follow-up dump.
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      repeat (20) tick();
    end
    wait_quiet(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_quiet_timeout: got busy, expected idle"); end
    model_dump();
    model_dump();
    tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL b2b_order: got [%s], expected [%s]", q2s(served), q2s(exp_q)); end
    gap = (load_cyc.size() > NUM_CH) ? load_cyc[NUM_CH] - load_cyc[NUM_CH-1] : -1;
    tests_run++; if (gap != WORD_CYC + 1) begin tests_failed++; $display("FAIL b2b_restart_gap: got %0d, expected %0d", gap, WORD_CYC + 1); end
    tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL b2b_protocol: got %0d errors, expected 0", proto_err); end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] mask;
    bit do_start, ok;
    int hold;
    for (int it = 0; it < 20; it++) begin
      clear_log();
      mask     = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      do_start = ($urandom_range(0, 3) == 0);
      hold     = $urandom_range(1, 30);
      req   = mask;
      start = do_start;
      tick();
      start = 1'b0;
      repeat (hold - 1) tick();
      req = '0;
      wait_quiet(600, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand%0d_quiet_timeout: got busy, expected idle", it); end
      // A dump taken alongside the edges serves, and clears, every source first.
      if (do_start) model_dump();
      else model_rr(mask);
      tests_run++; if (order_diff() != 0) begin tests_failed++; $display("FAIL rand%0d_order (mask %b start %0d): got [%s], expected [%s]", it, mask, do_start, q2s(served), q2s(exp_q)); end
      tests_run++; if (proto_err != 0) begin tests_failed++; $display("FAIL rand%0d_protocol: got %0d errors, expected 0", it, proto_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PERIODIC_DUMP_EN
    test_periodic();
`else
    test_single_req();
    test_dump();
    test_round_robin();
    test_dump_edges();
    test_reset_midshift();
    test_back_to_back();
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
